lap_recorder: RTL and testbench

- Stopwatch lap-memory stage, directly upstream of the pause/lap display mux.
- Captures the live {minutes, seconds, centiseconds} value into one of five lap slots on each lap request while the stopwatch runs.
- Produces the slot contents, per-slot empty flags, the browse index for the display, and a capture-flash indicator.
- While paused, the browse button steps through the filled slots and the clear button empties all slots.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/btn_edge.sv | 28 ++
 rtl/lap_recorder.sv | 151 +++++++++++++++
 tb/tb_lap_recorder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared lap-record definitions for the stopwatch lap memory.
package stopwatch_pkg;

    localparam int NSLOT = 5;
    localparam int TW    = 7;
    localparam int REC_W = 3 * TW;

    typedef logic [REC_W-1:0] lap_rec_t;
    typedef logic [2:0]       slot_idx_t;

    localparam lap_rec_t  EMPTY_REC = 21'd0;
    localparam slot_idx_t NSLOT_U   = 3'd5;

    // Packs {minutes, seconds, centiseconds} verbatim into one record.
    function automatic lap_rec_t pack_rec(input logic [TW-1:0] mm,
                                          input logic [TW-1:0] ss,
                                          input logic [TW-1:0] cc);
        return {mm, ss, cc};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge strobe for a debounced level button: one-cycle pulse per press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic strobe
);

    logic btn_q;
    logic btn_d;

    // Next value of the delayed button copy.
    always_comb begin
        btn_d = btn;
    end

    // Delayed copy of the button level.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign strobe = btn & ~btn_q;

endmodule

// File: rtl/lap_recorder.sv
// Lap memory: captures live time into five slots while running, lets the
// user browse or clear them while paused, and flashes on each capture.
module lap_recorder
    import stopwatch_pkg::*;
#(
    parameter logic [23:0] FLASH_CYCLES = 24'd5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        lap_btn,
    input  logic        browse_btn,
    input  logic        clr_btn,
    input  logic [6:0]  m,
    input  logic [6:0]  s,
    input  logic [6:0]  sms,
    output logic [20:0] dat1,
    output logic [20:0] dat2,
    output logic [20:0] dat3,
    output logic [20:0] dat4,
    output logic [20:0] dat5,
    output logic        o1,
    output logic        o2,
    output logic        o3,
    output logic        o4,
    output logic        o5,
    output logic [2:0]  num,
    output logic        pulse,
    output logic        full
);

    logic lap_ev;
    logic browse_ev;
    logic clr_ev;

    btn_edge u_lap_edge (
        .clk    (clk),
        .reset  (reset),
        .btn    (lap_btn),
        .strobe (lap_ev)
    );

    btn_edge u_browse_edge (
        .clk    (clk),
        .reset  (reset),
        .btn    (browse_btn),
        .strobe (browse_ev)
    );

    btn_edge u_clr_edge (
        .clk    (clk),
        .reset  (reset),
        .btn    (clr_btn),
        .strobe (clr_ev)
    );

    lap_rec_t         dat_q [NSLOT];
    lap_rec_t         dat_d [NSLOT];
    logic [NSLOT-1:0] o_q,     o_d;
    slot_idx_t        wp_q,    wp_d;
    slot_idx_t        cnt_q,   cnt_d;
    slot_idx_t        num_q,   num_d;
    logic [23:0]      flash_q, flash_d;
    logic             full_q,  full_d;
    logic             capture;

    // Next-state for slots, pointers, browse index and flash timer.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            dat_d[i] = dat_q[i];
        end
        o_d     = o_q;
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        flash_d = flash_q;

        capture = lap_ev && run && (cnt_q < NSLOT_U);

        if (capture) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (wp_q == slot_idx_t'(i)) begin
                    dat_d[i] = pack_rec(m, s, sms);
                    o_d[i]   = 1'b0;
                end
            end
            wp_d    = wp_q + 3'd1;
            cnt_d   = cnt_q + 3'd1;
            flash_d = FLASH_CYCLES;
        end else if (flash_q != 24'd0) begin
            flash_d = flash_q - 24'd1;
        end

        // Running always shows live time; clear beats browse when paused.
        if (run) begin
            num_d = 3'd0;
        end else if (clr_ev) begin
            for (int i = 0; i < NSLOT; i++) begin
                dat_d[i] = EMPTY_REC;
            end
            o_d   = '1;
            wp_d  = 3'd0;
            cnt_d = 3'd0;
            num_d = 3'd0;
        end else if (browse_ev) begin
            num_d = (num_q < cnt_q) ? num_q + 3'd1 : 3'd0;
        end

        full_d = (cnt_d == NSLOT_U);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSLOT; i++) begin
                dat_q[i] <= EMPTY_REC;
            end
            o_q     <= '1;
            wp_q    <= 3'd0;
            cnt_q   <= 3'd0;
            num_q   <= 3'd0;
            flash_q <= 24'd0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                dat_q[i] <= dat_d[i];
            end
            o_q     <= o_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            flash_q <= flash_d;
            full_q  <= full_d;
        end
    end

    assign dat1  = dat_q[0];
    assign dat2  = dat_q[1];
    assign dat3  = dat_q[2];
    assign dat4  = dat_q[3];
    assign dat5  = dat_q[4];
    assign o1    = o_q[0];
    assign o2    = o_q[1];
    assign o3    = o_q[2];
    assign o4    = o_q[3];
    assign o5    = o_q[4];
    assign num   = num_q;
    assign pulse = (flash_q != 24'd0);
    assign full  = full_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: a queue-based lap model predicts each
// cycle's outputs; a negedge monitor pops and compares.
module tb_lap_recorder;

    localparam int FC = 4;

    logic        clk = 1'b0;
    logic        reset, run, lap_btn, browse_btn, clr_btn;
    logic [6:0]  m, s, sms;
    logic [20:0] dat1, dat2, dat3, dat4, dat5;
    logic        o1, o2, o3, o4, o5;
    logic [2:0]  num;
    logic        pulse, full;

    always #5 clk = ~clk;

    lap_recorder #(.FLASH_CYCLES(24'd4)) dut (
        .clk(clk), .reset(reset), .run(run), .lap_btn(lap_btn),
        .browse_btn(browse_btn), .clr_btn(clr_btn),
        .m(m), .s(s), .sms(sms),
        .dat1(dat1), .dat2(dat2), .dat3(dat3), .dat4(dat4), .dat5(dat5),
        .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5),
        .num(num), .pulse(pulse), .full(full)
    );

    typedef struct packed {
        logic [4:0][20:0] dat;
        logic [4:0]       o;
        logic [2:0]       num;
        logic             pulse;
        logic             full;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: stored laps as a plain list, flash as a countdown.
    int unsigned laps[$];
    int          flash_left = 0;
    int          browse_idx = 0;
    bit          p_lap = 0, p_br = 0, p_clr = 0;

    task automatic model_step();
        bit   lap_ev, br_ev, clr_ev;
        exp_t e;
        lap_ev = lap_btn && !p_lap;
        br_ev  = browse_btn && !p_br;
        clr_ev = clr_btn && !p_clr;
        if (reset) begin
            laps.delete();
            flash_left = 0;
            browse_idx = 0;
            p_lap = 0; p_br = 0; p_clr = 0;
        end else begin
            p_lap = lap_btn; p_br = browse_btn; p_clr = clr_btn;
            if (lap_ev && run && laps.size() < 5) begin
                laps.push_back((int'(m) << 14) | (int'(s) << 7) | int'(sms));
                flash_left = FC;
            end else if (flash_left > 0) begin
                flash_left--;
            end
            if (run) begin
                browse_idx = 0;
            end else if (clr_ev) begin
                laps.delete();
                browse_idx = 0;
            end else if (br_ev) begin
                browse_idx = (browse_idx < laps.size()) ? browse_idx + 1 : 0;
            end
        end
        for (int i = 0; i < 5; i++) begin
            e.dat[i] = (i < laps.size()) ? 21'(laps[i]) : 21'd0;
            e.o[i]   = (i >= laps.size());
        end
        e.num   = 3'(browse_idx);
        e.pulse = (flash_left > 0);
        e.full  = (laps.size() == 5);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0][20:0] ad;
            e  = exp_q.pop_front();
            ad = {dat5, dat4, dat3, dat2, dat1};
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("dat%0d", i + 1), 32'(ad[i]), 32'(e.dat[i]));
            end
            chk("empty", 32'({o5, o4, o3, o2, o1}), 32'(e.o));
            chk("num", 32'(num), 32'(e.num));
            chk("pulse", 32'(pulse), 32'(e.pulse));
            chk("full", 32'(full), 32'(e.full));
        end
    end

    task automatic step(input bit r, input bit rn, input bit lp, input bit br,
                        input bit cl, input int mm, input int ss, input int cc);
        reset = r; run = rn; lap_btn = lp; browse_btn = br; clr_btn = cl;
        m = 7'(mm); s = 7'(ss); sms = 7'(cc);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input bit rn, input int n);
        for (int i = 0; i < n; i++) step(0, rn, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lap_once();
        step(0, 1, 1, 0, 0, $urandom_range(0, 99), $urandom_range(0, 59), $urandom_range(0, 99));
        step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic browse_once();
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; run = 0; lap_btn = 0; browse_btn = 0; clr_btn = 0;
        m = 0; s = 0; sms = 0;
        #1;
        do_reset();

        // Single capture and flash window.
        idle(1, 1);
        step(0, 1, 1, 0, 0, 1, 23, 45);
        idle(1, 7);

        // Six laps: the sixth is dropped once full.
        do_reset();
        for (int i = 0; i < 5; i++) lap_once();
        idle(1, 6);
        lap_once();
        idle(1, 3);

        // Browse sequence over three laps, then a held button.
        do_reset();
        for (int i = 0; i < 3; i++) lap_once();
        idle(0, 2);
        for (int i = 0; i < 6; i++) browse_once();
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        idle(0, 2);
        for (int i = 0; i < 3; i++) browse_once();
        idle(1, 2);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        idle(1, 1);

        // Run rising with a browse edge, then browse and clear together.
        idle(0, 1);
        browse_once();
        step(0, 1, 0, 1, 0, 0, 0, 0);
        idle(0, 1);
        browse_once();
        step(0, 0, 0, 1, 1, 0, 0, 0);
        idle(0, 1);

        // Clear while paused, then capture again; clear while running is ignored.
        do_reset();
        for (int i = 0; i < 3; i++) lap_once();
        step(0, 1, 0, 0, 1, 0, 0, 0);
        idle(1, 1);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 2);
        lap_once();
        idle(1, 2);

        // Reset in the middle of a flash.
        do_reset();
        lap_once();
        lap_once();
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 3);

        // Randomized phase.
        begin
            bit rn = 1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 39) == 0) rn = ~rn;
                step($urandom_range(0, 499) == 0, rn,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 99), $urandom_range(0, 59), $urandom_range(0, 99));
            end
        end
        idle(0, 2);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
